// File: rtl/turbo_pkg.sv
// Shared turbo-decoder types: alpha scheduler FSM encoding, metric vectors and HALF constants.
package turbo_pkg;

    localparam int BITS   = 16;
    localparam int STATES = 4;

    typedef logic [BITS-1:0] metric_t;
    typedef metric_t [STATES-1:0] alpha_vec_t;

    localparam metric_t HALF_ZERO    = 16'h0000;
    localparam metric_t HALF_NEG_INF = 16'hFC00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } alpha_sched_state_t;

endpackage

// File: rtl/alpha_scheduler.sv
// Forward (alpha) recursion sequencer: steps an external alpha_element through one block,
// feeding each result back as previousAlpha and writing every alpha vector to memory.
module alpha_scheduler #(
    parameter int                BITS           = 16,
    parameter int                STATES         = 4,
    parameter int                OUTPUT_SYMBOLS = 4,
    parameter int                ADDR_BITS      = 10,
    parameter logic [BITS-1:0]   ZERO_METRIC    = 16'h0000,
    parameter logic [BITS-1:0]   NEG_METRIC     = 16'hFC00
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ADDR_BITS-1:0]                 block_len,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 bm_rd_en,
    output logic [ADDR_BITS-1:0]                 bm_rd_addr,
    input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  bm_rd_data,
    output logic                                 elem_in_valid,
    output logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  elem_branch_metric,
    output logic [STATES-1:0][BITS-1:0]          elem_prev_alpha,
    input  logic                                 elem_out_valid,
    input  logic [STATES-1:0][BITS-1:0]          elem_alpha,
    output logic                                 alpha_wr_en,
    output logic [ADDR_BITS-1:0]                 alpha_wr_addr,
    output logic [STATES-1:0][BITS-1:0]          alpha_wr_data
);

    import turbo_pkg::*;

    function automatic logic [STATES-1:0][BITS-1:0] init_alpha();
        logic [STATES-1:0][BITS-1:0] v;
        for (int s = 0; s < STATES; s++) begin
            v[s] = (s == 0) ? ZERO_METRIC : NEG_METRIC;
        end
        return v;
    endfunction

    alpha_sched_state_t            state_q, state_d;
    logic [ADDR_BITS-1:0]          k_q, k_d;
    logic [ADDR_BITS-1:0]          len_q, len_d;
    logic [ADDR_BITS-1:0]          k_inc;
    logic [STATES-1:0][BITS-1:0]   alpha_q, alpha_d;
    logic [STATES-1:0][BITS-1:0]   wdata_q, wdata_d;
    logic                          err_q, err_d;

    assign k_inc           = k_q + ADDR_BITS'(1);
    assign elem_prev_alpha = alpha_q;
    assign err             = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            alpha_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            alpha_q <= alpha_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        k_d                = k_q;
        len_d              = len_q;
        alpha_d            = alpha_q;
        wdata_d            = wdata_q;
        err_d              = err_q;
        busy               = (state_q != S_IDLE) && (state_q != S_DONE);
        done               = 1'b0;
        bm_rd_en           = 1'b0;
        bm_rd_addr         = '0;
        elem_in_valid      = 1'b0;
        elem_branch_metric = '0;
        alpha_wr_en        = 1'b0;
        alpha_wr_addr      = '0;
        alpha_wr_data      = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = block_len;
                    err_d   = 1'b0;
                    k_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                alpha_d       = init_alpha();
                alpha_wr_en   = 1'b1;
                alpha_wr_data = init_alpha();
                state_d       = (len_q == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                bm_rd_en   = 1'b1;
                bm_rd_addr = k_q;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                elem_in_valid      = 1'b1;
                elem_branch_metric = bm_rd_data;
                state_d            = S_WAIT;
            end
            S_WAIT: begin
                if (elem_out_valid) begin
                    alpha_d = elem_alpha;
                    wdata_d = elem_alpha;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                alpha_wr_en   = 1'b1;
                alpha_wr_addr = k_inc;
                if (k_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_inc;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort cancels everything the current state would have done, including its strobes.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            k_d           = k_q;
            alpha_d       = alpha_q;
            wdata_d       = wdata_q;
            done          = 1'b0;
            bm_rd_en      = 1'b0;
            elem_in_valid = 1'b0;
            alpha_wr_en   = 1'b0;
        end

        // A result outside WAIT (e.g. late after abort) is flagged and never captured.
        if (elem_out_valid && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

endmodule
